// File: rtl/probe_trigger_pkg.sv
// Shared command codes, states, trigger modes and tag bytes for the probe
// capture front-end.
package probe_trigger_pkg;

  localparam logic [31:0] CMD_CLEAR = 32'hDEAD_DEAD;
  localparam logic [31:0] CMD_RUN   = 32'hDEAD_CAFE;

  localparam logic [7:0] TAG_PRE  = 8'h00;
  localparam logic [7:0] TAG_TRIG = 8'hFF;
  localparam logic [7:0] TAG_POST = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_EQ     = 2'd0,
    MODE_NE     = 2'd1,
    MODE_RISE   = 2'd2,
    MODE_CHANGE = 2'd3
  } mode_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/probe_trigger_if.sv
// Probe sample bus: the sampled logic-analyser inputs and their valid flag.
interface probe_trigger_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] sample;
  logic              sample_valid;

  modport master (output sample, output sample_valid);
  modport slave  (input  sample, input  sample_valid);
endinterface

// File: rtl/probe_trigger_trig_match.sv
// Combinational trigger comparator: masked (in)equality against a value, or
// rising edge / any change relative to the previous processed sample.
module trig_match
  import probe_trigger_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] cur_i,
  input  logic [DATA_W-1:0] prev_i,
  input  logic              prev_valid_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic [DATA_W-1:0] mask_i,
  input  mode_e             mode_i,
  output logic              match_o
);

  always_comb begin
    match_o = 1'b0;
    case (mode_i)
      MODE_EQ:     match_o = (((cur_i ^ value_i) & mask_i) == '0);
      MODE_NE:     match_o = (((cur_i ^ value_i) & mask_i) != '0);
      // Edge modes need a reference sample, so the first one after arming never matches.
      MODE_RISE:   match_o = prev_valid_i && (|(cur_i & ~prev_i & mask_i));
      MODE_CHANGE: match_o = prev_valid_i && (|((cur_i ^ prev_i) & mask_i));
      default:     match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/probe_trigger.sv
// Capture front-end: 2-stage pipeline (sample regs, then tagged word), trigger
// FSM with consecutive-match qualifier and post-trigger word budget.
module probe_trigger
  import probe_trigger_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int TAG_W      = 8,
  parameter int POST_WORDS = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [31:0]             cmd_i,
  probe_trigger_if.slave          probe_if,
  input  logic [DATA_W-1:0]       trig_value_i,
  input  logic [DATA_W-1:0]       trig_mask_i,
  input  logic [1:0]              trig_mode_i,
  input  logic [7:0]              trig_count_i,
  output logic [TAG_W+DATA_W-1:0] probe_data_o,
  output logic                    probe_wea_o,
  output logic [1:0]              state_o,
  output logic                    triggered_o,
  output logic [7:0]              post_cnt_o
);

  localparam logic [8:0] POST_LAST = 9'(POST_WORDS);

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       cfg_value_q, cfg_value_d;
  logic [DATA_W-1:0]       cfg_mask_q, cfg_mask_d;
  mode_e                   cfg_mode_q, cfg_mode_d;
  logic [7:0]              cfg_count_q, cfg_count_d;
  logic [7:0]              match_cnt_q, match_cnt_d;
  logic [8:0]              post_q, post_d;
  logic                    have_prev_q, have_prev_d;
  logic                    triggered_q, triggered_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_prev_valid_q, s1_prev_valid_d;
  logic [DATA_W-1:0]       s1_cur_q, s1_cur_d;
  logic [DATA_W-1:0]       s1_prev_q, s1_prev_d;
  logic [TAG_W+DATA_W-1:0] data_q, data_d;
  logic                    wea_q, wea_d;
  logic                    accept_s;
  logic                    match_s;
  logic [7:0]              count_req_s;

  assign accept_s = probe_if.sample_valid && (cmd_i == CMD_RUN) &&
                    ((state_q == ST_ARMED) || (state_q == ST_TRIGGERED));
  assign count_req_s = (cfg_count_q == 8'd0) ? 8'd1 : cfg_count_q;

  trig_match #(.DATA_W(DATA_W)) u_match (
    .cur_i        (s1_cur_q),
    .prev_i       (s1_prev_q),
    .prev_valid_i (s1_prev_valid_q),
    .value_i      (cfg_value_q),
    .mask_i       (cfg_mask_q),
    .mode_i       (cfg_mode_q),
    .match_o      (match_s)
  );

  // Next-state: stage-1 capture, stage-2 tagging, FSM and counters.
  always_comb begin
    state_d         = state_q;
    cfg_value_d     = cfg_value_q;
    cfg_mask_d      = cfg_mask_q;
    cfg_mode_d      = cfg_mode_q;
    cfg_count_d     = cfg_count_q;
    match_cnt_d     = match_cnt_q;
    post_d          = post_q;
    have_prev_d     = have_prev_q;
    triggered_d     = triggered_q;
    s1_valid_d      = accept_s;
    s1_prev_valid_d = s1_prev_valid_q;
    s1_cur_d        = s1_cur_q;
    s1_prev_d       = s1_prev_q;
    data_d          = data_q;
    wea_d           = 1'b0;

    if (accept_s) begin
      s1_cur_d        = probe_if.sample;
      s1_prev_d       = s1_cur_q;
      s1_prev_valid_d = have_prev_q;
      have_prev_d     = 1'b1;
    end else begin
      have_prev_d     = have_prev_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_i == CMD_RUN) begin
          state_d     = ST_ARMED;
          cfg_value_d = trig_value_i;
          cfg_mask_d  = trig_mask_i;
          cfg_mode_d  = mode_e'(trig_mode_i);
          cfg_count_d = trig_count_i;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (s1_valid_q) begin
          wea_d  = 1'b1;
          data_d = {TAG_W'(TAG_PRE), s1_cur_q};
          if (match_s) begin
            match_cnt_d = sat_inc8(match_cnt_q);
            if (match_cnt_d == count_req_s) begin
              data_d      = {TAG_W'(TAG_TRIG), s1_cur_q};
              triggered_d = 1'b1;
              post_d      = 9'd1;
              state_d     = (POST_LAST <= 9'd1) ? ST_DONE : ST_TRIGGERED;
            end else begin
              state_d     = ST_ARMED;
            end
          end else begin
            match_cnt_d = 8'd0;
          end
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_TRIGGERED: begin
        if (s1_valid_q) begin
          wea_d   = 1'b1;
          data_d  = {TAG_W'(TAG_POST), s1_cur_q};
          post_d  = post_q + 9'd1;
          state_d = (post_d >= POST_LAST) ? ST_DONE : ST_TRIGGERED;
        end else begin
          state_d = ST_TRIGGERED;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    // Clear overrides everything, including a sample arriving in the same cycle.
    if (cmd_i == CMD_CLEAR) begin
      state_d         = ST_IDLE;
      match_cnt_d     = 8'd0;
      post_d          = 9'd0;
      have_prev_d     = 1'b0;
      triggered_d     = 1'b0;
      s1_valid_d      = 1'b0;
      s1_prev_valid_d = 1'b0;
      wea_d           = 1'b0;
    end else begin
      state_d         = state_d;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      cfg_value_q     <= '0;
      cfg_mask_q      <= '0;
      cfg_mode_q      <= MODE_EQ;
      cfg_count_q     <= 8'd0;
      match_cnt_q     <= 8'd0;
      post_q          <= 9'd0;
      have_prev_q     <= 1'b0;
      triggered_q     <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_prev_valid_q <= 1'b0;
      s1_cur_q        <= '0;
      s1_prev_q       <= '0;
      data_q          <= '0;
      wea_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cfg_value_q     <= cfg_value_d;
      cfg_mask_q      <= cfg_mask_d;
      cfg_mode_q      <= cfg_mode_d;
      cfg_count_q     <= cfg_count_d;
      match_cnt_q     <= match_cnt_d;
      post_q          <= post_d;
      have_prev_q     <= have_prev_d;
      triggered_q     <= triggered_d;
      s1_valid_q      <= s1_valid_d;
      s1_prev_valid_q <= s1_prev_valid_d;
      s1_cur_q        <= s1_cur_d;
      s1_prev_q       <= s1_prev_d;
      data_q          <= data_d;
      wea_q           <= wea_d;
    end
  end

  assign probe_data_o = data_q;
  assign probe_wea_o  = wea_q;
  assign state_o      = state_q;
  assign triggered_o  = triggered_q;
  assign post_cnt_o   = (post_q > 9'd255) ? 8'hFF : post_q[7:0];

endmodule

// File: tb/tb_probe_trigger.sv
// Directed bench for probe_trigger: vector tables for trigger modes, pause and
// clear, plus streaming sequences for the post-trigger budget and reset.
module tb_probe_trigger;
  import probe_trigger_pkg::*;

  localparam logic [31:0] RUN = CMD_RUN;
  localparam logic [31:0] CLR = CMD_CLEAR;
  localparam logic [31:0] PAU = 32'h0000_0000;
  localparam logic [7:0]  T0  = 8'h00;
  localparam logic [7:0]  TF  = 8'hFF;
  localparam logic [7:0]  T1  = 8'h01;
  localparam logic        Y   = 1'b1;
  localparam logic        N   = 1'b0;
  localparam logic [1:0]  S0  = 2'd0;
  localparam logic [1:0]  S1  = 2'd1;
  localparam logic [1:0]  S2  = 2'd2;
  localparam logic [63:0] Z   = 64'h0;
  localparam logic [63:0] H   = 64'h5A;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] cmd_i;
  logic [63:0] trig_value_i;
  logic [63:0] trig_mask_i;
  logic [1:0]  trig_mode_i;
  logic [7:0]  trig_count_i;
  logic [71:0] probe_data_o;
  logic        probe_wea_o;
  logic [1:0]  state_o;
  logic        triggered_o;
  logic [7:0]  post_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  probe_trigger_if #(.DATA_W(64)) pif ();

  probe_trigger dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .cmd_i        (cmd_i),
    .probe_if     (pif),
    .trig_value_i (trig_value_i),
    .trig_mask_i  (trig_mask_i),
    .trig_mode_i  (trig_mode_i),
    .trig_count_i (trig_count_i),
    .probe_data_o (probe_data_o),
    .probe_wea_o  (probe_wea_o),
    .state_o      (state_o),
    .triggered_o  (triggered_o),
    .post_cnt_o   (post_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd;
    logic        vld;
    logic [63:0] smp;
    logic [63:0] tval;
    logic        ewea;
    logic [7:0]  etag;
    logic [63:0] esmp;
    logic [1:0]  est;
    logic        etrg;
    logic [7:0]  epost;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] cur_tval;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] cmd, input logic vld, input logic [63:0] smp,
                     input logic ewea, input logic [7:0] etag, input logic [63:0] esmp,
                     input logic [1:0] est, input logic etrg, input logic [7:0] epost);
    vec_t v;
    v.cmd = cmd; v.vld = vld; v.smp = smp; v.tval = cur_tval;
    v.ewea = ewea; v.etag = etag; v.esmp = esmp; v.est = est; v.etrg = etrg; v.epost = epost;
    tbl.push_back(v);
  endtask

  // Each row: check outputs of the current cycle, then drive that row's inputs.
  task automatic apply_table(input string seg);
    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("%s[%0d] wea", seg, i), 72'(probe_wea_o), 72'(tbl[i].ewea));
      if (tbl[i].ewea)
        chk($sformatf("%s[%0d] data", seg, i), probe_data_o, {tbl[i].etag, tbl[i].esmp});
      chk($sformatf("%s[%0d] state", seg, i), 72'(state_o), 72'(tbl[i].est));
      chk($sformatf("%s[%0d] trig", seg, i), 72'(triggered_o), 72'(tbl[i].etrg));
      chk($sformatf("%s[%0d] post", seg, i), 72'(post_cnt_o), 72'(tbl[i].epost));
      cmd_i            = tbl[i].cmd;
      pif.sample_valid = tbl[i].vld;
      pif.sample       = tbl[i].smp;
      trig_value_i     = tbl[i].tval;
    end
    tbl.delete();
  endtask

  task automatic do_clear();
    @(negedge clk);
    cmd_i            = CLR;
    pif.sample_valid = N;
  endtask

  function automatic logic [63:0] sample_of(input int k);
    logic [23:0] kk;
    kk = 24'(k);
    if (k == 2) return H;
    return {32'hA5A5_0000, kk, 8'h00};
  endfunction

  // Continuous valid samples; trigger expected on processed sample index trig.
  task automatic run_stream(input string name, input int nsamp, input int trig);
    int k;
    int p;
    do_clear();
    @(negedge clk);
    cmd_i = RUN;
    for (int c = 0; c < nsamp + 3; c++) begin
      @(negedge clk);
      k = c - 2;
      if (k >= 0 && k < nsamp && k <= trig + 255) begin
        chk($sformatf("%s[%0d] wea", name, k), 72'(probe_wea_o), 72'(1));
        if (k < trig) begin
          chk($sformatf("%s[%0d] data", name, k), probe_data_o, {T0, sample_of(k)});
          chk($sformatf("%s[%0d] state", name, k), 72'(state_o), 72'(S1));
          chk($sformatf("%s[%0d] trig", name, k), 72'(triggered_o), 72'(0));
        end else begin
          p = k - trig + 1;
          chk($sformatf("%s[%0d] data", name, k), probe_data_o,
              {(k == trig) ? TF : T1, sample_of(k)});
          chk($sformatf("%s[%0d] state", name, k), 72'(state_o), 72'((p >= 256) ? 3 : 2));
          chk($sformatf("%s[%0d] trig", name, k), 72'(triggered_o), 72'(1));
          chk($sformatf("%s[%0d] post", name, k), 72'(post_cnt_o), 72'((p > 255) ? 255 : p));
        end
      end else begin
        chk($sformatf("%s c%0d idle wea", name, c), 72'(probe_wea_o), 72'(0));
      end
      if (c < nsamp) begin
        pif.sample_valid = Y;
        pif.sample       = sample_of(c);
      end else begin
        pif.sample_valid = N;
      end
    end
    chk($sformatf("%s final state", name), 72'(state_o),
        72'((nsamp - 1 >= trig + 255) ? 3 : 2));
  endtask

  initial begin
    rst_ni = 1'b0; cmd_i = PAU; pif.sample_valid = N; pif.sample = Z;
    trig_value_i = Z; trig_mask_i = Z; trig_mode_i = 2'd0; trig_count_i = 8'd0;
    cur_tval = H;
    #3;
    chk("reset data", probe_data_o, 72'h0);
    chk("reset wea", 72'(probe_wea_o), 72'(0));
    chk("reset state", 72'(state_o), 72'(0));
    chk("reset trig", 72'(triggered_o), 72'(0));
    chk("reset post", 72'(post_cnt_o), 72'(0));
    @(negedge clk);
    rst_ni = 1'b1;

    // Count 3: hit,hit,miss,hit,hit,hit; value changes after arming; pause; clear; re-arm.
    do_clear();
    trig_mask_i = 64'hFF; trig_mode_i = 2'd0; trig_count_i = 8'd3;
    cur_tval = H;
    add(RUN, N, Z,     N, T0, Z, S0, N, 8'd0);
    cur_tval = Z;
    add(RUN, Y, H,     N, T0, Z, S1, N, 8'd0);
    add(RUN, Y, H,     N, T0, Z, S1, N, 8'd0);
    add(RUN, Y, Z,     Y, T0, H, S1, N, 8'd0);
    add(RUN, Y, H,     Y, T0, H, S1, N, 8'd0);
    add(RUN, Y, H,     Y, T0, Z, S1, N, 8'd0);
    add(RUN, Y, H,     Y, T0, H, S1, N, 8'd0);
    add(RUN, N, Z,     Y, T0, H, S1, N, 8'd0);
    add(RUN, N, Z,     Y, TF, H, S2, Y, 8'd1);
    add(RUN, Y, 64'h11, N, T0, Z, S2, Y, 8'd1);
    add(RUN, Y, 64'h22, N, T0, Z, S2, Y, 8'd1);
    add(PAU, Y, 64'h33, Y, T1, 64'h11, S2, Y, 8'd2);
    add(PAU, Y, 64'h44, Y, T1, 64'h22, S2, Y, 8'd3);
    for (int i = 0; i < 8; i++) add(PAU, Y, 64'h55, N, T0, Z, S2, Y, 8'd3);
    add(RUN, Y, 64'h66, N, T0, Z, S2, Y, 8'd3);
    add(RUN, N, Z,     N, T0, Z, S2, Y, 8'd3);
    add(RUN, N, Z,     Y, T1, 64'h66, S2, Y, 8'd4);
    add(RUN, Y, 64'h77, N, T0, Z, S2, Y, 8'd4);
    add(RUN, Y, 64'h88, N, T0, Z, S2, Y, 8'd4);
    add(CLR, Y, 64'h99, Y, T1, 64'h77, S2, Y, 8'd5);
    add(PAU, Y, 64'hAA, N, T0, Z, S0, N, 8'd0);
    add(PAU, N, Z,     N, T0, Z, S0, N, 8'd0);
    cur_tval = H;
    add(RUN, N, Z,     N, T0, Z, S0, N, 8'd0);
    add(RUN, Y, H,     N, T0, Z, S1, N, 8'd0);
    add(RUN, Y, H,     N, T0, Z, S1, N, 8'd0);
    add(RUN, Y, H,     Y, T0, H, S1, N, 8'd0);
    add(RUN, N, Z,     Y, T0, H, S1, N, 8'd0);
    add(RUN, N, Z,     Y, TF, H, S2, Y, 8'd1);
    apply_table("cnt");

    // Rising edge on bit 4, armed with bit 4 already high.
    do_clear();
    trig_mask_i = 64'h10; trig_mode_i = 2'd2; trig_count_i = 8'd1; cur_tval = Z;
    add(RUN, N, Z,     N, T0, Z, S0, N, 8'd0);
    add(RUN, Y, 64'h10, N, T0, Z, S1, N, 8'd0);
    add(RUN, Y, 64'h00, N, T0, Z, S1, N, 8'd0);
    add(RUN, Y, 64'h10, Y, T0, 64'h10, S1, N, 8'd0);
    add(RUN, N, Z,     Y, T0, 64'h00, S1, N, 8'd0);
    add(RUN, N, Z,     Y, TF, 64'h10, S2, Y, 8'd1);
    add(RUN, N, Z,     N, T0, Z, S2, Y, 8'd1);
    apply_table("rise");

    // Any change on the low nibble, count 2; bit 5 is unmasked.
    do_clear();
    trig_mask_i = 64'h0F; trig_mode_i = 2'd3; trig_count_i = 8'd2; cur_tval = Z;
    add(RUN, N, Z,     N, T0, Z, S0, N, 8'd0);
    add(RUN, Y, 64'h01, N, T0, Z, S1, N, 8'd0);
    add(RUN, Y, 64'h01, N, T0, Z, S1, N, 8'd0);
    add(RUN, Y, 64'h21, Y, T0, 64'h01, S1, N, 8'd0);
    add(RUN, Y, 64'h22, Y, T0, 64'h01, S1, N, 8'd0);
    add(RUN, Y, 64'h23, Y, T0, 64'h21, S1, N, 8'd0);
    add(RUN, N, Z,     Y, T0, 64'h22, S1, N, 8'd0);
    add(RUN, N, Z,     Y, TF, 64'h23, S2, Y, 8'd1);
    apply_table("chg");

    // Masked not-equal with count 0 (acts as 1).
    do_clear();
    trig_mask_i = 64'hF0; trig_mode_i = 2'd1; trig_count_i = 8'd0; cur_tval = 64'h30;
    add(RUN, N, Z,     N, T0, Z, S0, N, 8'd0);
    add(RUN, Y, 64'h35, N, T0, Z, S1, N, 8'd0);
    add(RUN, Y, 64'h4F, N, T0, Z, S1, N, 8'd0);
    add(RUN, N, Z,     Y, T0, 64'h35, S1, N, 8'd0);
    add(RUN, N, Z,     Y, TF, 64'h4F, S2, Y, 8'd1);
    apply_table("ne");

    // Full capture to DONE, then trigger on the 255th consecutive match.
    trig_mask_i = 64'hFF; trig_mode_i = 2'd0; trig_count_i = 8'd1; trig_value_i = H;
    run_stream("maskeq", 303, 2);
    trig_mask_i = Z; trig_mode_i = 2'd0; trig_count_i = 8'd255;
    run_stream("cnt255", 260, 254);

    // Asynchronous reset in the middle of a capture.
    trig_mask_i = 64'hFF; trig_mode_i = 2'd0; trig_count_i = 8'd1; trig_value_i = H;
    do_clear();
    @(negedge clk); cmd_i = RUN;
    @(negedge clk); pif.sample_valid = Y; pif.sample = H;
    @(negedge clk); pif.sample = 64'h1;
    @(negedge clk); pif.sample = 64'h2;
    chk("rst pre trig", 72'(triggered_o), 72'(1));
    @(negedge clk); pif.sample = 64'h3;
    chk("rst pre wea", 72'(probe_wea_o), 72'(1));
    #2 rst_ni = 1'b0;
    #1;
    chk("rst async data", probe_data_o, 72'h0);
    chk("rst async wea", 72'(probe_wea_o), 72'(0));
    chk("rst async state", 72'(state_o), 72'(0));
    chk("rst async trig", 72'(triggered_o), 72'(0));
    chk("rst async post", 72'(post_cnt_o), 72'(0));
    @(negedge clk);
    cmd_i = PAU; pif.sample_valid = N; rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post-rst idle %0d", i), 72'(state_o), 72'(0));
    end
    cmd_i = RUN;
    @(negedge clk);
    chk("post-rst arm", 72'(state_o), 72'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
